// File: rtl/opicorv32_pkg.sv
// Shared PCPI issue definitions: FSM encoding, RV32M field constants, default timeout.
// No logic; no latency or backpressure of its own.
package opicorv32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [6:0] PCPI_OP_OP     = 7'b0110011;
    localparam logic [6:0] PCPI_F7_MULDIV = 7'b0000001;

    localparam int TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/opicorv32_pcpi_timeout.sv
// Saturating count of unclaimed PCPI valid cycles; expired is a compare on the registered count.
// Latency: expired reflects the count one cycle after enable; clear dominates enable.
module opicorv32_pcpi_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == LAST);

    // Holding at LAST keeps the counter from wrapping if the owner lingers.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/opicorv32_pcpi_issue.sv
// Core-side PCPI initiator: issues one instruction, waits for ready or timeout, returns a 1-cycle response.
// Latency: accept->pcpi_valid 1 cycle, pcpi_ready->rsp_valid 1 cycle; req_ready high only in IDLE.
module opicorv32_pcpi_issue
    import opicorv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic        abort,
    output logic        rsp_valid,
    output logic        rsp_wr,
    output logic [31:0] rsp_rd,
    output logic        rsp_illegal,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready
);

    state_e      state_q, state_d;
    logic        pcpi_valid_q, pcpi_valid_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_wr_q, rsp_wr_d;
    logic [31:0] rsp_rd_q, rsp_rd_d;
    logic        rsp_illegal_q, rsp_illegal_d;

    logic        tmo_clear;
    logic        tmo_enable;
    logic        tmo_expired;

    // A claiming coprocessor (pcpi_wait) restarts the unclaimed-cycle window.
    assign tmo_clear  = (state_q != ST_BUSY) || pcpi_wait;
    assign tmo_enable = (state_q == ST_BUSY) && !pcpi_wait;

    opicorv32_pcpi_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d       = state_q;
        pcpi_valid_d  = pcpi_valid_q;
        insn_d        = insn_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rsp_valid_d   = 1'b0;
        rsp_wr_d      = rsp_wr_q;
        rsp_rd_d      = rsp_rd_q;
        rsp_illegal_d = rsp_illegal_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && !abort) begin
                    insn_d       = req_insn;
                    rs1_d        = req_rs1;
                    rs2_d        = req_rs2;
                    pcpi_valid_d = 1'b1;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Priority: abort, then ready (even with wait or expiry), then timeout.
                if (abort) begin
                    pcpi_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else if (pcpi_ready) begin
                    pcpi_valid_d  = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_wr_d      = pcpi_wr;
                    rsp_rd_d      = pcpi_rd;
                    rsp_illegal_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (!pcpi_wait && tmo_expired) begin
                    pcpi_valid_d  = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_wr_d      = 1'b0;
                    rsp_rd_d      = '0;
                    rsp_illegal_d = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                pcpi_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            pcpi_valid_q  <= 1'b0;
            insn_q        <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_wr_q      <= 1'b0;
            rsp_rd_q      <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pcpi_valid_q  <= pcpi_valid_d;
            insn_q        <= insn_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_wr_q      <= rsp_wr_d;
            rsp_rd_q      <= rsp_rd_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign pcpi_valid  = pcpi_valid_q;
    assign pcpi_insn   = insn_q;
    assign pcpi_rs1    = rs1_q;
    assign pcpi_rs2    = rs2_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_wr      = rsp_wr_q;
    assign rsp_rd      = rsp_rd_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_opicorv32_pcpi_issue.sv
// Scoreboard bench for opicorv32_pcpi_issue: scripted/random PCPI responder, queue-based expected results.
module tb_opicorv32_pcpi_issue;
    import opicorv32_pkg::*;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_insn = '0;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic        abort = 1'b0;
    logic        rsp_valid;
    logic        rsp_wr;
    logic [31:0] rsp_rd;
    logic        rsp_illegal;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr = 1'b0;
    logic [31:0] pcpi_rd = '0;
    logic        pcpi_wait = 1'b0;
    logic        pcpi_ready = 1'b0;

    always #5 clk = ~clk;

    opicorv32_pcpi_issue #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .abort(abort),
        .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_rd(rsp_rd), .rsp_illegal(rsp_illegal),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
    );

    typedef struct {
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          len;      // 0 = length not checked
        logic        has_rsp;
    } vexp_t;

    typedef struct {
        logic        wr;
        logic [31:0] rd;
        logic        ill;
    } rexp_t;

    vexp_t vq[$];
    rexp_t rq[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mul_ref(input logic [31:0] insn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        if (insn[6:0] == PCPI_OP_OP && insn[31:25] == PCPI_F7_MULDIV && insn[14:12] == 3'b000)
            return p[31:0];
        return 32'h0;
    endfunction

    // Outcome from the rules: abort beats ready, ready beats timeout, a wait cycle
    // restarts the window, T consecutive unclaimed cycles make it illegal.
    // kind: 0 aborted, 1 legal, 2 illegal.
    task automatic ref_model(input int ws, input int wl, input int ra, input int aa,
                             output int kind, output int len);
        int run;
        run = 0; kind = 0; len = 0;
        for (int c = 1; c <= 400 && len == 0; c++) begin
            if (aa == c) begin
                kind = 0; len = c;
            end else if (ra == c) begin
                kind = 1; len = c;
            end else if (c >= ws && c < ws + wl) begin
                run = 0;
            end else begin
                run++;
                if (run == T) begin
                    kind = 2; len = c;
                end
            end
        end
    endtask

    // Monitor: pcpi_valid run length/operand stability, response scoreboard.
    int vcnt = 0;
    bit op_ok = 1'b1;
    always @(negedge clk) begin
        vexp_t ve;
        rexp_t re;
        if (pcpi_valid) begin
            if (vcnt == 0) op_ok = 1'b1;
            vcnt++;
            if (vq.size() > 0 && (pcpi_insn !== vq[0].insn || pcpi_rs1 !== vq[0].rs1 ||
                                  pcpi_rs2 !== vq[0].rs2))
                op_ok = 1'b0;
        end else if (vcnt > 0) begin
            if (vq.size() == 0) begin
                chk("valid_unexpected", 32'(vq.size()), 32'd1);
            end else begin
                ve = vq.pop_front();
                if (ve.len != 0) chk("valid_len", 32'(vcnt), 32'(ve.len));
                chk("rsp_latency", 32'(rsp_valid), 32'(ve.has_rsp));
                chk("pcpi_operands", 32'(op_ok), 32'd1);
            end
            vcnt = 0;
        end
        if (rsp_valid) begin
            chk("valid_low_in_rsp", 32'(pcpi_valid), 32'd0);
            if (rq.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                re = rq.pop_front();
                chk("rsp_wr", 32'(rsp_wr), 32'(re.wr));
                chk("rsp_rd", rsp_rd, re.rd);
                chk("rsp_illegal", 32'(rsp_illegal), 32'(re.ill));
            end
        end
    end

    task automatic drive_idle();
        pcpi_wait = 1'b0; pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0; abort = 1'b0;
    endtask

    // One transaction: ws/wl = wait window start/length, ra = ready cycle (0 none),
    // aa = abort cycle (0 none); cycles numbered from the first pcpi_valid cycle.
    task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic wr, input logic [31:0] rdv,
                           input int ws, input int wl, input int ra, input int aa, input bit late);
        int kind, len;
        vexp_t ve;
        rexp_t re;
        ref_model(ws, wl, ra, aa, kind, len);
        ve.insn = insn; ve.rs1 = rs1; ve.rs2 = rs2; ve.len = len; ve.has_rsp = (kind != 0);
        vq.push_back(ve);
        if (kind != 0) begin
            re.wr  = (kind == 1) ? wr : 1'b0;
            re.rd  = (kind == 1) ? rdv : 32'h0;
            re.ill = (kind == 2);
            rq.push_back(re);
        end
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_insn = insn; req_rs1 = rs1; req_rs2 = rs2;
        @(posedge clk); #1;
        req_valid = 1'b0; req_insn = $urandom; req_rs1 = $urandom; req_rs2 = $urandom;
        for (int c = 1; c <= 400; c++) begin
            pcpi_wait  = (c >= ws && c < ws + wl);
            pcpi_ready = (c == ra);
            pcpi_wr    = (c == ra) ? wr : 1'($urandom);
            pcpi_rd    = (c == ra) ? rdv : $urandom;
            abort      = (c == aa);
            @(posedge clk); #1;
            if (!pcpi_valid) break;
        end
        chk("busy_bound", 32'(pcpi_valid), 32'd0);
        drive_idle();
        if (kind != 0) begin
            if (late) begin
                pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = $urandom;
            end
            @(posedge clk); #1;
            drive_idle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] insn, a, b, rdv;
        logic        wr;
        int          ws, wl, ra, aa;
        bit          stale;

        repeat (2) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_pcpi_valid", 32'(pcpi_valid), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rd", rsp_rd, 32'd0);
        chk("reset_rsp_flags", {30'd0, rsp_wr, rsp_illegal}, 32'd0);
        chk("reset_pcpi_insn", pcpi_insn, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // MUL a0,a0,a1 with 7*6 from a multi-cycle multiplier.
        run_txn(32'h02B50533, 32'd7, 32'd6, 1'b1, mul_ref(32'h02B50533, 32'd7, 32'd6), 1, 3, 4, 0, 0);
        // No responder: exactly T valid cycles, then illegal.
        run_txn(32'h0000000B, 32'h1234, 32'h5678, 1'b1, 32'hFFFF_FFFF, 1, 0, 0, 0, 1);
        // Long claim, then result.
        run_txn(32'h02B50533, 32'd3, 32'd9, 1'b1, 32'hDEADBEEF, 1, 100, 101, 0, 0);
        // Ready on the final timeout cycle wins.
        run_txn(32'h0000000B, 32'd1, 32'd2, 1'b1, 32'h5, 1, 0, T, 0, 0);
        // Abort on cycle 3 with ready pending later; next request on the following cycle.
        run_txn(32'h02B50533, 32'd11, 32'd12, 1'b1, 32'd132, 1, 5, 6, 3, 0);
        run_txn(32'h02C58633, 32'd100, 32'd5, 1'b1, mul_ref(32'h02C58633, 32'd100, 32'd5), 1, 2, 3, 0, 0);
        // Ready together with wait.
        run_txn(32'h02B50533, 32'd4, 32'd4, 1'b0, 32'h77, 1, 10, 5, 0, 0);

        // Abort in IDLE suppresses a concurrent request.
        @(negedge clk);
        req_valid = 1'b1; abort = 1'b1; req_insn = 32'hCAFE0001;
        @(posedge clk); #1;
        chk("idle_abort_no_valid", 32'(pcpi_valid), 32'd0);
        chk("idle_abort_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0; abort = 1'b0;

        for (int i = 0; i < 60; i++) begin
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                insn = {PCPI_F7_MULDIV, 5'($urandom), 5'($urandom), 3'b000, 5'($urandom), PCPI_OP_OP};
                rdv  = mul_ref(insn, a, b);
                wr   = 1'b1;
                ws   = $urandom_range(1, 3);
                wl   = $urandom_range(0, 40);
                ra   = ($urandom_range(0, 3) == 0) ? ws + wl + $urandom_range(0, 20) : ws + wl;
                if (ra == 0) ra = 1;
            end else begin
                insn = {25'($urandom), 7'h0B};
                rdv  = $urandom;
                wr   = 1'($urandom);
                ws   = 1; wl = 0; ra = 0;
            end
            aa = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : 0;
            run_txn(insn, a, b, wr, rdv, ws, wl, ra, aa, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Asynchronous reset in the middle of BUSY.
        begin
            vexp_t ve;
            ve.insn = 32'h0000002B; ve.rs1 = 32'h1; ve.rs2 = 32'h2; ve.len = 0; ve.has_rsp = 1'b0;
            vq.push_back(ve);
            @(negedge clk);
            req_valid = 1'b1; req_insn = ve.insn; req_rs1 = ve.rs1; req_rs2 = ve.rs2;
            @(posedge clk); #1;
            req_valid = 1'b0;
            repeat (5) @(posedge clk);
            #1 resetn = 1'b0;
            #1;
            chk("areset_pcpi_valid", 32'(pcpi_valid), 32'd0);
            chk("areset_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("areset_req_ready", 32'(req_ready), 32'd1);
            repeat (2) @(negedge clk);
            resetn = 1'b1;
            stale = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (rsp_valid) stale = 1'b1;
            end
            chk("no_stale_rsp", 32'(stale), 32'd0);
        end
        // Counter restarts from zero after reset.
        run_txn(32'h0000000B, 32'h9, 32'h8, 1'b0, 32'h0, 1, 0, 0, 0, 0);

        repeat (5) @(negedge clk);
        chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
        chk("valid_queue_empty", 32'(vq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
